des_key_sched: RTL and testbench
================================

Name: des_key_sched

Overview:
- Sequential DES key-schedule generator. Produces the 16 48-bit round subkeys in either encryption order (K1..K16, left rotations) or decryption order (K16..K1, right rotations).
- Internally: PC-1 on load, per-round C/D rotation, PC-2 compression on output.
- Feeds the round datapath one subkey per valid/ready handshake, so a single key load serves either direction.

Parameters:
- NUM_ROUNDS, 16, subkeys per schedule. Fixed by DES; only 16 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- key_in  input  [1:64]  64-bit DES key, bit 1 = MSB; parity bits 8,16,..,64 ignored
- decrypt  input  1  direction select, sampled with key_load: 0 = K1 first, 1 = K16 first
- key_load  input  1  load request; accepted only when key_ready=1
- key_ready  output  1  high in IDLE, i.e. able to accept key_load
- abort  input  1  synchronous return to IDLE, no done pulse
- sk_out  output  [1:48]  current subkey, PC-2 of registered C||D
- sk_round  output  4  index of current subkey minus 1 (0 = K1, 15 = K16)
- sk_valid  output  1  sk_out/sk_round valid
- sk_ready  input  1  consumer accepts current subkey
- done  output  1  one-cycle pulse after last subkey accepted

Behaviour:
- State registers: FSM {IDLE, OUT}; C[1:28], D[1:28]; round counter rnd[3:0]; dir flag; done reg.
- Reset (async, rst_n=0):
  - state=IDLE, C=D=0, rnd=0, dir=0, done=0.
  - Outputs: key_ready=1, sk_valid=0, sk_round=0, done=0, sk_out=PC2(0)=0.
- Shift table s(r), r=1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28).
- IDLE, key_load=1, abort=0 → OUT next cycle. With {C,D}=PC1(key_in) and dir=decrypt:
  - encrypt: C,D = rotl(PC1 halves, 1); rnd=0.
  - decrypt: C,D = PC1 halves unrotated (K16 state); rnd=15.
- Latency: first subkey valid in the cycle after key_load acceptance.
- OUT: sk_valid=1, key_ready=0. sk_out and sk_round are held stable while sk_valid=1 and sk_ready=0.
- Handshake (sk_valid & sk_ready) on a non-final subkey:
  - encrypt: rnd+1; C,D rotl by s(rnd+2) (the next round's shift).
  - decrypt: rnd-1; C,D rotr by s(rnd+1) (the current round's shift).
  - Next subkey valid the following cycle. Back-to-back handshakes give 1 subkey/cycle.
- Final handshake (encrypt rnd=15, decrypt rnd=0):
  - → IDLE; done=1 for exactly the next cycle; key_ready=1 in that same cycle.
  - sk_valid=0 from that cycle.
- C/D hold their final values in IDLE (encrypt ends at the K16 state = original PC1 halves).
- key_load while in OUT: ignored. key_load coincident with the final handshake: ignored (key_ready was 0 in that cycle).
- abort=1 in any state:
  - → IDLE next cycle, sk_valid=0, no done.
  - abort has priority over key_load and over a same-cycle handshake.
- decrypt input is sampled only at load; changes mid-schedule have no effect.
- Rotations are circular within each 28-bit half, independently for C and D.
- Async reset mid-schedule: immediate return to reset values, no done.

Test Plan:
- Encrypt key 133457799BBCDFF1, decrypt=0, sk_ready tied 1 → sk_valid 16 consecutive cycles starting the cycle after load:
  - K1=1B02EFFC7072 (sk_round 0), K2=79AED9DBC9E5, …, K16=CB3D8B0E17F5 (sk_round 15).
  - done pulses once the next cycle; key_ready returns 1.
- Same key, decrypt=1 → first sk_out=CB3D8B0E17F5 with sk_round=15, second=second-to-last encrypt key (K15), last=1B02EFFC7072 with sk_round=0; full 16-key sequence is the exact reverse of the encrypt run.
- Backpressure: sk_ready low for 5 cycles on K3 → sk_out=K3 and sk_round=2 held stable. On release, K4 appears the next cycle; no key skipped or duplicated.
- Random sk_ready over 200 loads of random keys, both directions → each sequence matches a software DES schedule model; exactly one done per load.
- key_load pulsed mid-schedule → ignored, sequence unaffected. abort at sk_round 7 → IDLE, no done, key_ready=1 next cycle; a fresh load restarts from K1.
- rst_n asserted asynchronously mid-schedule (between clock edges) → outputs reach reset values immediately. Parity-bit-only key changes (flip bits 8,16,...,64) → identical subkeys.

Source files
------------

// File: rtl/des_key_sched.sv
// DES key-schedule generator: emits the 16 round subkeys one per valid/ready
// handshake, in encryption (K1..K16) or decryption (K16..K1) order.
module des_key_sched #(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:64] key_in,
  input  logic        decrypt,
  input  logic        key_load,
  output logic        key_ready,
  input  logic        abort,
  output logic [1:48] sk_out,
  output logic [3:0]  sk_round,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic        done
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OUT  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:28] c_q, c_d;
  logic [1:28] d_q, d_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        dir_q, dir_d;
  logic        done_q, done_d;

  logic [1:56] pc1_cd;
  logic [1:56] cd;
  logic        last_rnd;
  logic        unused_parity;

  // Shift amount s(idx+1) is 2 except for rounds 1, 2, 9 and 16.
  function automatic logic shift_is_two(input logic [3:0] idx);
    return !((idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15));
  endfunction

  function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
    return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
    return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
  endfunction

  // PC-1: permuted choice of the 56 key bits; parity bits are dropped.
  always_comb begin
    pc1_cd = {key_in[57], key_in[49], key_in[41], key_in[33], key_in[25], key_in[17], key_in[9],
              key_in[1],  key_in[58], key_in[50], key_in[42], key_in[34], key_in[26], key_in[18],
              key_in[10], key_in[2],  key_in[59], key_in[51], key_in[43], key_in[35], key_in[27],
              key_in[19], key_in[11], key_in[3],  key_in[60], key_in[52], key_in[44], key_in[36],
              key_in[63], key_in[55], key_in[47], key_in[39], key_in[31], key_in[23], key_in[15],
              key_in[7],  key_in[62], key_in[54], key_in[46], key_in[38], key_in[30], key_in[22],
              key_in[14], key_in[6],  key_in[61], key_in[53], key_in[45], key_in[37], key_in[29],
              key_in[21], key_in[13], key_in[5],  key_in[28], key_in[20], key_in[12], key_in[4]};
    unused_parity = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                      key_in[40], key_in[48], key_in[56], key_in[64]};
  end

  // PC-2: compress the registered C||D into the 48-bit subkey.
  always_comb begin
    cd     = {c_q, d_q};
    sk_out = {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],  cd[3],  cd[28],
              cd[15], cd[6],  cd[21], cd[10], cd[23], cd[19], cd[12], cd[4],
              cd[26], cd[8],  cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
              cd[41], cd[52], cd[31], cd[37], cd[47], cd[55], cd[30], cd[40],
              cd[51], cd[45], cd[33], cd[48], cd[44], cd[49], cd[39], cd[56],
              cd[34], cd[53], cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};
  end

  // Next-state: load, per-handshake rotation, final-subkey wrap-up, abort.
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    d_d      = d_q;
    rnd_d    = rnd_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    last_rnd = dir_q ? (rnd_q == 4'd0) : (rnd_q == LAST_RND);

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (key_load) begin
            state_d = ST_OUT;
            dir_d   = decrypt;
            // Decryption starts at K16, whose cumulative rotation of 28 is identity.
            if (decrypt) begin
              c_d   = pc1_cd[1:28];
              d_d   = pc1_cd[29:56];
              rnd_d = LAST_RND;
            end else begin
              c_d   = rotl(pc1_cd[1:28], 1'b0);
              d_d   = rotl(pc1_cd[29:56], 1'b0);
              rnd_d = 4'd0;
            end
          end
        end
        ST_OUT: begin
          if (sk_ready) begin
            if (last_rnd) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (dir_q) begin
              // Undo the current round's shift to step back one round.
              rnd_d = rnd_q - 4'd1;
              c_d   = rotr(c_q, shift_is_two(rnd_q));
              d_d   = rotr(d_q, shift_is_two(rnd_q));
            end else begin
              rnd_d = rnd_q + 4'd1;
              c_d   = rotl(c_q, shift_is_two(rnd_q + 4'd1));
              d_d   = rotl(d_q, shift_is_two(rnd_q + 4'd1));
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      rnd_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      rnd_q   <= rnd_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // Registered outputs.
  always_comb begin
    key_ready = (state_q == ST_IDLE);
    sk_valid  = (state_q == ST_OUT);
    sk_round  = rnd_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched against a table-driven DES key-schedule model.
module tb_des_key_sched;

  logic        clk;
  logic        rst_n;
  logic [63:0] key_in;
  logic        decrypt;
  logic        key_load;
  logic        key_ready;
  logic        abort;
  logic [47:0] sk_out;
  logic [3:0]  sk_round;
  logic        sk_valid;
  logic        sk_ready;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [47:0] seq     [16];
  logic [47:0] enc_seq [16];

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
    26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_sched #(.NUM_ROUNDS(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .decrypt  (decrypt),
    .key_load (key_load),
    .key_ready(key_ready),
    .abort    (abort),
    .sk_out   (sk_out),
    .sk_round (sk_round),
    .sk_valid (sk_valid),
    .sk_ready (sk_ready),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Subkey K_r computed directly: PC-1, cumulative left rotation, PC-2.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int r);
    int          sh = 0;
    logic [27:0] c0, d0;
    logic [55:0] cdr;
    logic [47:0] o;
    for (int i = 0; i < r; i++) sh += SHIFTS[i];
    for (int i = 0; i < 28; i++) begin
      c0[5'(i)] = key[6'(64 - PC1_T[i])];
      d0[5'(i)] = key[6'(64 - PC1_T[28 + i])];
    end
    for (int i = 0; i < 28; i++) begin
      cdr[6'(i)]      = c0[5'((i + sh) % 28)];
      cdr[6'(28 + i)] = d0[5'((i + sh) % 28)];
    end
    for (int j = 0; j < 48; j++) o[6'(47 - j)] = cdr[6'(PC2_T[j] - 1)];
    return o;
  endfunction

  // One full schedule from IDLE; call with time at posedge+1.
  task automatic run_sched(input logic [63:0] key, input bit dec, input bit rnd_ready,
                           input int hold_k, input int poke_k, input int abort_k);
    int k = 0;
    int hold = 0;
    int cyc = 0;
    int r;
    bit fin = 0;
    bit aborted = 0;
    bit did_abort;
    chk("key_ready_idle", key_ready, 1);
    key_in   = key;
    decrypt  = dec;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    while (!fin && cyc < 200) begin
      cyc++;
      r = dec ? 16 - k : k + 1;
      chk("sk_valid", sk_valid, 1);
      chk("key_ready_busy", key_ready, 0);
      chk("done_busy", done, 0);
      chk("sk_round", sk_round, 64'(r - 1));
      chk("sk_out", sk_out, ref_subkey(key, r));
      seq[k] = sk_out;
      sk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == hold_k && hold < 5) begin
        sk_ready = 1'b0;
        hold++;
      end
      key_in = {$urandom, $urandom};
      if (rnd_ready) decrypt = 1'($urandom_range(0, 1));
      key_load = (k == poke_k);
      if (sk_ready && k == 15 && rnd_ready) key_load = 1'($urandom_range(0, 1));
      did_abort = (k == abort_k);
      if (did_abort) begin
        abort    = 1'b1;
        sk_ready = 1'b1;
      end
      @(posedge clk); #1;
      key_load = 1'b0;
      if (did_abort) begin
        abort    = 1'b0;
        sk_ready = 1'b0;
        chk("abort_valid", sk_valid, 0);
        chk("abort_key_ready", key_ready, 1);
        chk("abort_no_done", done, 0);
        @(posedge clk); #1;
        chk("abort_no_done2", done, 0);
        chk("abort_valid2", sk_valid, 0);
        aborted = 1;
        fin     = 1;
      end else if (sk_ready) begin
        k++;
        if (k == 16) fin = 1;
      end
    end
    if (!fin) begin
      chk("sched_timeout", 0, 1);
    end else if (!aborted) begin
      sk_ready = 1'b0;
      chk("done_pulse", done, 1);
      chk("key_ready_after", key_ready, 1);
      chk("valid_after", sk_valid, 0);
      @(posedge clk); #1;
      chk("done_once", done, 0);
      chk("valid_after2", sk_valid, 0);
    end
    sk_ready = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    key_in   = '0;
    decrypt  = 1'b0;
    key_load = 1'b0;
    abort    = 1'b0;
    sk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_ready", key_ready, 1);
    chk("rst_sk_valid", sk_valid, 0);
    chk("rst_sk_round", sk_round, 0);
    chk("rst_done", done, 0);
    chk("rst_sk_out", sk_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer encrypt run
    run_sched(KEY, 1'b0, 1'b0, -1, -1, -1);
    for (int i = 0; i < 16; i++) enc_seq[i] = seq[i];
    chk("kat_k1", enc_seq[0], 48'h1B02EFFC7072);
    chk("kat_k2", enc_seq[1], 48'h79AED9DBC9E5);
    chk("kat_k16", enc_seq[15], 48'hCB3D8B0E17F5);

    // Decrypt run must be the exact reverse
    run_sched(KEY, 1'b1, 1'b0, -1, -1, -1);
    for (int i = 0; i < 16; i++) chk("dec_reverse", seq[i], enc_seq[15 - i]);

    // Backpressure on K3, key_load poke mid-schedule, abort at round 7 then fresh load
    run_sched(KEY, 1'b0, 1'b0, 2, -1, -1);
    run_sched(KEY, 1'b0, 1'b0, -1, 5, -1);
    run_sched(KEY, 1'b0, 1'b0, -1, -1, 7);
    run_sched(KEY, 1'b0, 1'b0, -1, -1, -1);
    run_sched(KEY, 1'b1, 1'b1, -1, -1, 4);

    // Parity bits must not affect subkeys
    run_sched(KEY ^ 64'h0101010101010101, 1'b0, 1'b0, -1, -1, -1);
    for (int i = 0; i < 16; i++) chk("parity_ignored", seq[i], enc_seq[i]);

    // Asynchronous reset between clock edges mid-schedule
    key_in   = KEY;
    decrypt  = 1'b0;
    key_load = 1'b1;
    sk_ready = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_key_ready", key_ready, 1);
    chk("arst_sk_valid", sk_valid, 0);
    chk("arst_sk_round", sk_round, 0);
    chk("arst_done", done, 0);
    chk("arst_sk_out", sk_out, 0);
    #2;
    rst_n    = 1'b1;
    sk_ready = 1'b0;
    @(posedge clk); #1;
    chk("arst_idle_valid", sk_valid, 0);
    chk("arst_idle_done", done, 0);

    // Random keys, directions and sk_ready
    for (int unsigned n = 0; n < 200; n++) begin
      run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
